exc_arbiter: RTL

EXC_ARBITER -- requirements
Module: exc_arbiter

---
 rtl/exc_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/exc_arbiter.sv
// exc_arbiter: MEM-stage exception arbiter. Picks the highest-priority
// exception for the instruction in MEM, forwards pending CP0 writes from WB,
// and issues a one-cycle registered flush with the redirect PC.
// Optional build macro: EXC_INT_SYNC_EN adds a 2-flop synchronizer on each
// external interrupt line (int_sync_o then lags int_raw_i by two clocks).
module exc_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_raw_i,
    output logic [5:0]  int_sync_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_delayslot_i,
    input  logic [10:0] mem_exc_i,
    input  logic [31:0] mem_vaddr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_ebase_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] bad_vaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    // Exception codes shared with CP0; zero means "no exception".
    localparam logic [31:0] EXCEPTION_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXCEPTION_ADEL      = 32'h0000_0004;
    localparam logic [31:0] EXCEPTION_ADES      = 32'h0000_0005;
    localparam logic [31:0] EXCEPTION_TLBL      = 32'h0000_0006;
    localparam logic [31:0] EXCEPTION_TLBS      = 32'h0000_0007;
    localparam logic [31:0] EXCEPTION_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXCEPTION_RI        = 32'h0000_000a;
    localparam logic [31:0] EXCEPTION_CPU       = 32'h0000_000b;
    localparam logic [31:0] EXCEPTION_TLBM      = 32'h0000_000c;
    localparam logic [31:0] EXCEPTION_ERET      = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] status_fwd, epc_fwd, ebase_fwd;
    logic [1:0]  cause_sw;
    logic [7:0]  cause_ip;
    logic        int_pending;
    logic [31:0] exc_code;
    logic [31:0] bad_vaddr;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= int_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign int_sync_o = sync2_q;
`else
    assign int_sync_o = rst ? 6'd0 : int_raw_i;
`endif

    // Forward a CP0 write still sitting in WB so MEM sees the newest values.
    // Only the software interrupt bits of cause are writable.
    always_comb begin
        status_fwd = cp0_status_i;
        epc_fwd    = cp0_epc_i;
        ebase_fwd  = cp0_ebase_i;
        cause_sw   = cp0_cause_i[9:8];
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_STATUS: status_fwd = wb_cp0_data_i;
                CP0_CAUSE:  cause_sw   = wb_cp0_data_i[9:8];
                CP0_EPC:    epc_fwd    = wb_cp0_data_i;
                CP0_EBASE:  ebase_fwd  = wb_cp0_data_i;
                default:    ;
            endcase
        end
    end

    // Hardware interrupt pending bits come from the (synchronized) lines.
    assign cause_ip    = {int_sync_o, cause_sw};
    assign int_pending = status_fwd[0] && !status_fwd[1] &&
                         ((cause_ip & status_fwd[15:8]) != 8'd0);

    // Priority select; interrupt wins over every synchronous flag, ERET is last.
    always_comb begin
        exc_code  = 32'd0;
        bad_vaddr = 32'd0;
        if (!rst && mem_valid_i && state_q == S_IDLE) begin
            if (int_pending) begin
                exc_code = EXCEPTION_INTERRUPT;
            end else if (mem_exc_i[0]) begin
                exc_code  = EXCEPTION_ADEL;
                bad_vaddr = mem_pc_i;
            end else if (mem_exc_i[1]) begin
                exc_code  = EXCEPTION_TLBL;
                bad_vaddr = mem_pc_i;
            end else if (mem_exc_i[2]) begin
                exc_code = EXCEPTION_RI;
            end else if (mem_exc_i[3]) begin
                exc_code = EXCEPTION_CPU;
            end else if (mem_exc_i[4]) begin
                exc_code = EXCEPTION_SYSCALL;
            end else if (mem_exc_i[6]) begin
                exc_code  = EXCEPTION_ADEL;
                bad_vaddr = mem_vaddr_i;
            end else if (mem_exc_i[7]) begin
                exc_code  = EXCEPTION_ADES;
                bad_vaddr = mem_vaddr_i;
            end else if (mem_exc_i[8]) begin
                exc_code  = EXCEPTION_TLBL;
                bad_vaddr = mem_vaddr_i;
            end else if (mem_exc_i[9]) begin
                exc_code  = EXCEPTION_TLBS;
                bad_vaddr = mem_vaddr_i;
            end else if (mem_exc_i[10]) begin
                exc_code  = EXCEPTION_TLBM;
                bad_vaddr = mem_vaddr_i;
            end else if (mem_exc_i[5]) begin
                exc_code = EXCEPTION_ERET;
            end
        end
    end

    assign excepttype_o    = exc_code;
    assign bad_vaddr_o     = bad_vaddr;
    assign exc_pc_o        = mem_pc_i;
    assign exc_delayslot_o = mem_delayslot_i;

    // Next state and redirect target; the target is latched only on detection.
    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        case (state_q)
            S_IDLE: begin
                if (exc_code != 32'd0) begin
                    state_d  = S_FLUSH;
                    new_pc_d = (exc_code == EXCEPTION_ERET) ? epc_fwd
                                                            : {ebase_fwd[31:12], 12'h180};
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and redirect PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            new_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush_o  = (state_q == S_FLUSH);
    assign new_pc_o = new_pc_q;

    // Bits of the CP0 inputs this block has no use for.
    logic unused_bits;
    assign unused_bits = ^{status_fwd[31:16], cp0_cause_i[31:10], cp0_cause_i[7:0],
                           ebase_fwd[11:0]};

endmodule
